sequenciador_interpretador: RTL

//  Controller that sequences the 5-bit -> 4-bit digit decoder (interpretador).

---
 rtl/sequenciador_interpretador.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sequenciador_interpretador.sv
// sequenciador_interpretador
// Steps a code index through 0..ULTIMO for the external 5-bit -> 4-bit digit
// decoder. Each index is held for DIV cycles, then the decoder output is
// captured into digito with a one-cycle valido strobe. A captured 4'hF sets
// the sticky erro flag. fim pulses with the valido of the last index.
//
// Parameters:
//   DIV     cycles each index is held before capture (>= 1)
//   ULTIMO  last index of the sequence (0..31)
//
// Configuration macro:
//   SEQ_REVERSO_EN  adds input direcao; 1 = count down from ULTIMO to 0.
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high
//   direcao       (SEQ_REVERSO_EN only) direction, sampled when iniciar is accepted
//   iniciar       start request, only honoured in IDLE
//   parar         abort to IDLE; overrides every other event
//   modo_ciclico  1 = wrap and keep running after the last index
//   digito_in     decoder output for the current indice
//   indice        decoder input
//   digito        last captured digit
//   valido        one-cycle pulse, digito updated
//   fim           one-cycle pulse, last index captured
//   ocupado       high while not IDLE
//   erro          sticky, a captured digit was 4'hF
module sequenciador_interpretador #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned ULTIMO = 8
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SEQ_REVERSO_EN
  input  logic       direcao,
`endif
  input  logic       iniciar,
  input  logic       parar,
  input  logic       modo_ciclico,
  input  logic [3:0] digito_in,
  output logic [4:0] indice,
  output logic [3:0] digito,
  output logic       valido,
  output logic       fim,
  output logic       ocupado,
  output logic       erro
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  localparam logic [4:0] Ultimo = 5'(ULTIMO);

  typedef enum logic [1:0] {StIdle, StDwell, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      indice_q, indice_d;
  logic [3:0]      digito_q, digito_d;
  logic            valido_q, valido_d;
  logic            fim_q, fim_d;
  logic            erro_q, erro_d;
  // Direction latched at start; constant zero when reverse mode is not built.
  logic            reverso_q, reverso_d;
  logic            dir_in;

`ifdef SEQ_REVERSO_EN
  assign dir_in = direcao;
`else
  assign dir_in = 1'b0;
`endif

  // First/last index of the sequence depend on the latched direction.
  logic [4:0] primeiro, ultimo_idx;
  assign primeiro   = reverso_q ? Ultimo : 5'd0;
  assign ultimo_idx = reverso_q ? 5'd0 : Ultimo;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    indice_d  = indice_q;
    digito_d  = digito_q;
    valido_d  = 1'b0;
    fim_d     = 1'b0;
    erro_d    = erro_q;
    reverso_d = reverso_q;

    unique case (state_q)
      StIdle: begin
        indice_d = 5'd0;
        cnt_d    = '0;
        if (iniciar) begin
          state_d   = StDwell;
          erro_d    = 1'b0;
          reverso_d = dir_in;
          indice_d  = dir_in ? Ultimo : 5'd0;
        end
      end
      StDwell: begin
        if (cnt_q == CntMax) begin
          cnt_d    = '0;
          digito_d = digito_in;
          valido_d = 1'b1;
          if (digito_in == 4'hF) erro_d = 1'b1;
          if (indice_q != ultimo_idx) begin
            indice_d = reverso_q ? (indice_q - 5'd1) : (indice_q + 5'd1);
          end else begin
            fim_d = 1'b1;
            if (modo_ciclico) indice_d = primeiro;
            else              state_d  = StDone;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d  = StIdle;
        indice_d = 5'd0;
      end
      default: begin
        state_d  = StIdle;
        indice_d = 5'd0;
        cnt_d    = '0;
      end
    endcase

    // Abort suppresses this edge's capture but keeps digito/erro history.
    if (parar) begin
      state_d   = StIdle;
      indice_d  = 5'd0;
      cnt_d     = '0;
      valido_d  = 1'b0;
      fim_d     = 1'b0;
      digito_d  = digito_q;
      erro_d    = erro_q;
      reverso_d = reverso_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      indice_q  <= 5'd0;
      digito_q  <= 4'd0;
      valido_q  <= 1'b0;
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
      reverso_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      indice_q  <= indice_d;
      digito_q  <= digito_d;
      valido_q  <= valido_d;
      fim_q     <= fim_d;
      erro_q    <= erro_d;
      reverso_q <= reverso_d;
    end
  end

  assign indice  = indice_q;
  assign digito  = digito_q;
  assign valido  = valido_q;
  assign fim     = fim_q;
  assign erro    = erro_q;
  assign ocupado = (state_q != StIdle);

endmodule
